// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: datapath width, opcodes and FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 24;

    typedef enum logic [2:0] {
        OP_PASSA = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_INC   = 3'b110,
        OP_MUL   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, valid pulses after the last bit.
import alu_pkg::*;

module alu_mul_iter #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               valid
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            active <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                count  <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                // The accumulate above lands on the same edge as valid, so product is final when valid is seen.
                if (count == CW'(WIDTH - 1)) begin
                    active <= 1'b0;
                    valid  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: latches operands on start, runs a one-cycle op or a 24-cycle multiply,
// and registers result, flags and a one-cycle write/done strobe on completion.
import alu_pkg::*;

module seq_alu #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             write,
    output logic             busy,
    output logic             done,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    state_e             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [WIDTH:0]     exec_res;
    logic               mul_load;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_valid;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;

    assign mul_load = (state == ST_IDLE) && start && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .valid   (mul_valid)
    );

    // Bit WIDTH of the extended result is carry for add/inc and borrow for sub.
    always_comb begin
        exec_res = '0;
        case (op_e'(op_q))
            OP_PASSA: exec_res = {1'b0, a_q};
            OP_ADD:   exec_res = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:   exec_res = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:   exec_res = {1'b0, a_q & b_q};
            OP_OR:    exec_res = {1'b0, a_q | b_q};
            OP_XOR:   exec_res = {1'b0, a_q ^ b_q};
            OP_INC:   exec_res = {1'b0, a_q} + (WIDTH+1)'(1);
            default:  exec_res = '0;
        endcase
    end

    always_comb begin
        fin_res = exec_res[WIDTH-1:0];
        fin_c   = exec_res[WIDTH];
        if (state == ST_MUL) begin
            fin_res = mul_product[WIDTH-1:0];
            fin_c   = |mul_product[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            result <= '0;
            write  <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            write <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        busy  <= 1'b1;
                        state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC, ST_MUL: begin
                    if (state == ST_EXEC || mul_valid) begin
                        result <= fin_res;
                        flag_z <= (fin_res == '0);
                        flag_n <= fin_res[WIDTH-1];
                        flag_c <= fin_c;
                        write  <= 1'b1;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expected values.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic [23:0] result;
    logic        write, busy, done, flag_z, flag_n, flag_c;

    int total = 0;
    int bad = 0;

    localparam logic [2:0] C_PASSA = 3'b000, C_ADD = 3'b001, C_SUB = 3'b010, C_AND = 3'b011,
                           C_OR = 3'b100, C_XOR = 3'b101, C_INC = 3'b110, C_MUL = 3'b111;

    seq_alu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .result(result), .write(write), .busy(busy), .done(done),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start for a single edge (edge N); returns just after edge N.
    task automatic issue(input logic [2:0] o, input logic [23:0] x, input logic [23:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = C_ADD; a = 24'd5; b = 24'd5;
        tick(); tick(); tick();
        total++;
        if ({busy, write, done, flag_z, flag_n, flag_c} !== 6'b0 || result !== 24'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b write=%b done=%b z=%b n=%b c=%b result=%h, want all 0",
                     busy, write, done, flag_z, flag_n, flag_c, result);
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(C_ADD, 24'd100, 24'd23);
        total++;
        if (busy !== 1'b1 || write !== 1'b0) begin
            bad++;
            $display("FAIL add_exec_cycle: got busy=%b write=%b, want busy=1 write=0", busy, write);
        end
        tick();
        total++;
        if (result !== 24'd123 || write !== 1'b1 || done !== 1'b1 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL add_done: got result=%0d write=%b done=%b z=%b c=%b, want 123 1 1 0 0",
                     result, write, done, flag_z, flag_c);
        end
        tick();
        total++;
        if (write !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || result !== 24'd123) begin
            bad++;
            $display("FAIL add_after: got write=%b done=%b busy=%b result=%0d, want 0 0 0 123",
                     write, done, busy, result);
        end
    endtask

    task automatic test_wrap_and_borrow();
        issue(C_ADD, 24'hFFFFFF, 24'd1);
        tick();
        total++;
        if (result !== 24'h000000 || flag_z !== 1'b1 || flag_c !== 1'b1 || write !== 1'b1) begin
            bad++;
            $display("FAIL add_wrap: got result=%h z=%b c=%b write=%b, want 000000 1 1 1",
                     result, flag_z, flag_c, write);
        end
        tick();
        issue(C_SUB, 24'd5, 24'd7);
        tick();
        total++;
        if (result !== 24'hFFFFFE || flag_n !== 1'b1 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow: got result=%h n=%b c=%b z=%b, want fffffe 1 1 0",
                     result, flag_n, flag_c, flag_z);
        end
        tick();
    endtask

    task automatic test_logic_ops();
        logic [2:0]  ops [5] = '{C_PASSA, C_AND, C_OR, C_INC, C_SUB};
        logic [23:0] va  [5] = '{24'h123456, 24'hF0F0F0, 24'hF00000, 24'hFFFFFF, 24'd9};
        logic [23:0] vb  [5] = '{24'hABCDEF, 24'h0FF0FF, 24'h00000F, 24'h000000, 24'd9};
        logic [23:0] ve  [5] = '{24'h123456, 24'h00F0F0, 24'hF0000F, 24'h000000, 24'h000000};
        logic        vc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], va[i], vb[i]);
            tick();
            total++;
            if (result !== ve[i] || flag_c !== vc[i] || flag_n !== ve[i][23] || write !== 1'b1) begin
                bad++;
                $display("FAIL op_vec%0d: got result=%h c=%b n=%b write=%b, want %h %b %b 1",
                         i, result, flag_c, flag_n, write, ve[i], vc[i], ve[i][23]);
            end
            tick();
        end
    endtask

    task automatic test_mul(input logic [23:0] x, input logic [23:0] y,
                            input logic [23:0] exp_res, input logic exp_c, input logic exp_z);
        int cnt;
        issue(C_MUL, x, y);
        cnt = 0;
        while (write !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt != 25 || result !== exp_res || flag_c !== exp_c || flag_z !== exp_z || done !== 1'b1) begin
            bad++;
            $display("FAIL mul_%h_%h: got edges=%0d result=%h c=%b z=%b done=%b, want 25 %h %b %b 1",
                     x, y, cnt, result, flag_c, flag_z, done, exp_res, exp_c, exp_z);
        end
        tick();
    endtask

    task automatic test_ignore_while_busy();
        int writes = 0, wr_cyc = -1, busy_drop = 0;
        logic [23:0] wr_res = '0;
        issue(C_MUL, 24'd3, 24'd5);
        for (int cnt = 1; cnt <= 32; cnt++) begin
            if (cnt == 5) begin
                start = 1'b1; op = C_ADD; a = 24'd1; b = 24'd2;
            end
            tick();
            start = 1'b0;
            if (write === 1'b1) begin
                writes++; wr_res = result; wr_cyc = cnt;
            end
            if (wr_cyc < 0 && busy !== 1'b1) busy_drop++;
        end
        total++;
        if (writes != 1 || wr_res !== 24'd15 || wr_cyc != 25 || busy_drop != 0) begin
            bad++;
            $display("FAIL ignore_busy: got writes=%0d result=%h at edge %0d busy_drops=%0d, want 1 00000f 25 0",
                     writes, wr_res, wr_cyc, busy_drop);
        end
    endtask

    task automatic test_reset_abort();
        int writes = 0;
        issue(C_MUL, 24'd1000, 24'd1000);
        for (int i = 1; i <= 9; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (busy !== 1'b0 || write !== 1'b0 || result !== 24'd0) begin
            bad++;
            $display("FAIL abort_state: got busy=%b write=%b result=%h, want 0 0 000000", busy, write, result);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (write === 1'b1) writes++;
        end
        total++;
        if (writes != 0 || result !== 24'd0) begin
            bad++;
            $display("FAIL abort_nowrite: got writes=%0d result=%h, want 0 000000", writes, result);
        end
        issue(C_INC, 24'h00000F, 24'd0);
        tick();
        total++;
        if (result !== 24'h000010 || write !== 1'b1 || flag_c !== 1'b0) begin
            bad++;
            $display("FAIL inc_after_abort: got result=%h write=%b c=%b, want 000010 1 0", result, write, flag_c);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(C_XOR, 24'hAAAAAA, 24'h555555);
        tick();
        total++;
        if (result !== 24'hFFFFFF || flag_n !== 1'b1 || write !== 1'b1) begin
            bad++;
            $display("FAIL b2b_xor: got result=%h n=%b write=%b, want ffffff 1 1", result, flag_n, write);
        end
        start = 1'b1; op = C_ADD; a = 24'd1; b = 24'd1;
        tick();
        total++;
        if (busy !== 1'b0 || write !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_start: got busy=%b write=%b, want 0 0", busy, write);
        end
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle_accept: got busy=%b, want 1", busy);
        end
        tick();
        total++;
        if (result !== 24'd2 || write !== 1'b1 || flag_n !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got result=%h write=%b n=%b, want 000002 1 0", result, write, flag_n);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap_and_borrow();
        test_logic_ops();
        test_mul(24'd1000, 24'd1000, 24'h0F4240, 1'b0, 1'b0);
        test_mul(24'h001000, 24'h001000, 24'h000000, 1'b1, 1'b1);
        test_mul(24'hFFFFFF, 24'd2, 24'hFFFFFE, 1'b1, 1'b0);
        test_ignore_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have one clock and reset: clk is the single clock; rst_n is synchronous and active-low.
REQ-002 SHALL expose parameter: WIDTH, 24, datapath width (matches GPR data_in/BUS_OUT).
REQ-003 SHALL expose ports (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  start  in  1  request operation; sampled on rising edge
  op  in  3  opcode (REQ-007)
  a  in  24  operand A (GPR MUX output)
  b  in  24  operand B (BUS_OUT)
  result  out  24  operation result; drives GPR data_in
  write  out  1  one-cycle GPR write strobe
  busy  out  1  operation in progress; start ignored
  done  out  1  one-cycle completion pulse, coincident with write
  flag_z  out  1  result == 0
  flag_n  out  1  result[23]
  flag_c  out  1  carry/borrow/overflow (REQ-009)

Function
REQ-004 SHALL accept start only when busy=0; on acceptance, latch a, b and op, and assert busy from the next cycle.
REQ-005 SHALL ignore start, a, b and op changes while busy=1; latched operands govern the operation.
REQ-006 SHALL implement FSM states IDLE, EXEC, MUL, DONE:
  - IDLE->EXEC on accepted start with op!=MUL.
  - IDLE->MUL on accepted start with op=MUL.
  - EXEC->DONE after 1 cycle.
  - MUL->DONE after exactly 24 iterations.
  - DONE->IDLE unconditionally.
REQ-007 SHALL decode op as: 000 PASSA, 001 ADD, 010 SUB (a-b), 011 AND, 100 OR, 101 XOR, 110 INC (a+1), 111 MUL.
REQ-008 SHALL meet the following latency, where N is the start-sampling edge:
  - Non-MUL ops: result, flags, write and done valid in the cycle after edge N+1.
  - MUL: shift-add, one partial-product bit per cycle; write and done in the cycle after edge N+25.
REQ-009 SHALL compute flag_c as follows:
  - ADD/INC: bit 24 of the 25-bit sum.
  - SUB: borrow (a<b, unsigned).
  - MUL: 1 if the upper 24 bits of the 48-bit product are nonzero.
  - Logic/PASSA: 0.
REQ-010 SHALL set result to the low 24 bits of the operation; arithmetic is unsigned modulo 2^24.
REQ-011 SHALL pulse write and done high for exactly one cycle (DONE state); busy is high in EXEC, MUL and DONE.
REQ-012 SHALL update result and flags only on completion, and hold them until the next completion.
REQ-013 SHALL permit back-to-back operation: a start asserted in the DONE cycle is ignored; a start sampled in the IDLE cycle after DONE is accepted.

Reset
REQ-014 SHALL, when rst_n=0 at a rising edge, set FSM=IDLE, result=0, flags=0, write=0, done=0, busy=0, and clear the multiplier accumulator and counter.
REQ-015 SHALL abort any in-flight operation on reset: no write pulse, and result keeps its reset value.
REQ-016 SHALL give reset priority over start in the same cycle.

Structure
REQ-017 SHALL place WIDTH, the opcode constants and the FSM state enum in shared package alu_pkg.
REQ-018 SHALL implement MUL in sub-module alu_mul_iter with interface load/operands in and 48-bit product/valid out, counter 0..23.
REQ-019 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-020 SHALL check ADD a=100, b=23: result=123, write=done=1 for one cycle after edge N+1, z=0, c=0.
REQ-021 SHALL check ADD a=0xFFFFFF, b=1: result=0, z=1, c=1; SUB a=5, b=7: result=0xFFFFFE, n=1, c=1.
REQ-022 SHALL check MUL a=1000, b=1000: result=0x0F4240 with write after edge N+25, c=0; and MUL a=0x001000, b=0x001000: result=0, z=1, c=1.
REQ-023 SHALL check that start with op=ADD and new operands, issued at N+5 during an in-progress MUL, is ignored: the single write carries the MUL result, and busy stays high until DONE.
REQ-024 SHALL check that rst_n=0 for one cycle at N+10 of a MUL gives: busy=0 next cycle, no write pulse, result=0; a subsequent INC a=0x00000F gives 0x000010.
REQ-025 SHALL check back-to-back operation: XOR 0xAAAAAA^0x555555 gives 0xFFFFFF with n=1; a start asserted in that DONE cycle is ignored, and a start in the next IDLE cycle is accepted.
